// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a registered read.
// Fetch (A) is locked out until the loader (B) signals boot_done, then round-robin.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_BOOT | program load: only the loader (B) may access the RAM
// ST_RUN  | normal operation: A and B share the RAM round-robin
module ram_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              boot_done,

  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic              last_b_q;
  logic              rd_a_q;
  logic              rd_b_q;
  logic [DATA_W-1:0] a_hold_q;
  logic [DATA_W-1:0] b_hold_q;

  // A only wins in RUN, and under contention only if B was granted last.
  always_comb begin
    a_gnt = (state_q == ST_RUN) && a_req && (!b_req || last_b_q);
    b_gnt = b_req && !a_gnt;
  end

  always_comb begin
    ram_read_en  = 1'b0;
    ram_write_en = 1'b0;
    ram_addr     = '0;
    ram_din      = '0;
    if (a_gnt) begin
      ram_read_en = 1'b1;
      ram_addr    = a_addr;
    end else if (b_gnt) begin
      ram_read_en  = ~b_we;
      ram_write_en = b_we;
      ram_addr     = b_addr;
      ram_din      = b_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_BOOT;
      last_b_q <= 1'b0;
      rd_a_q   <= 1'b0;
      rd_b_q   <= 1'b0;
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      if (state_q == ST_BOOT && boot_done) begin
        state_q <= ST_RUN;
      end

      if (a_gnt) begin
        last_b_q <= 1'b0;
      end else if (b_gnt) begin
        last_b_q <= 1'b1;
      end

      // Read-owner tag: matches the RAM's one-cycle read latency.
      rd_a_q <= a_gnt;
      rd_b_q <= b_gnt && !b_we;

      if (rd_a_q) begin
        a_hold_q <= ram_dout;
      end
      if (rd_b_q) begin
        b_hold_q <= ram_dout;
      end
    end
  end

  // Return data passes straight through in its valid cycle, then holds.
  assign a_rvalid = rd_a_q;
  assign b_rvalid = rd_b_q;
  assign a_rdata  = rd_a_q ? ram_dout : a_hold_q;
  assign b_rdata  = rd_b_q ? ram_dout : b_hold_q;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, RAM address width (128 words).
REQ-002 Parameter DATA_W, default 16, RAM word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 boot_done  input  1  single-cycle pulse; ends program-load phase.
REQ-006 a_req  input  1  fetch requester read request; held until a_gnt.
REQ-007 a_addr  input  ADDR_W  fetch read address; stable while a_req high.
REQ-008 a_gnt  output  1  fetch request accepted this cycle.
REQ-009 a_rvalid  output  1  a_rdata valid; one cycle after a_gnt.
REQ-010 a_rdata  output  DATA_W  fetch read data.
REQ-011 b_req  input  1  loader requester request; held until b_gnt.
REQ-012 b_we  input  1  loader access type: 1 write, 0 read.
REQ-013 b_addr  input  ADDR_W  loader address; stable while b_req high.
REQ-014 b_wdata  input  DATA_W  loader write data; stable while b_req high.
REQ-015 b_gnt  output  1  loader request accepted this cycle.
REQ-016 b_rvalid  output  1  b_rdata valid; one cycle after a read b_gnt.
REQ-017 b_rdata  output  DATA_W  loader read data.
REQ-018 ram_read_en  output  1  to RAM read enable.
REQ-019 ram_write_en  output  1  to RAM write enable.
REQ-020 ram_addr  output  ADDR_W  to RAM address.
REQ-021 ram_din  output  DATA_W  to RAM write data.
REQ-022 ram_dout  input  DATA_W  from RAM; registered read, valid one cycle after read_en.

Function
REQ-023 State machine SHALL have two states: BOOT (after reset) and RUN; BOOT->RUN on boot_done high at a clock edge; RUN is terminal until reset.
REQ-024 In BOOT, only requester B SHALL be granted; a_req SHALL be ignored (a_gnt=0), a_req remains pending.
REQ-025 In RUN, at most one grant per cycle; sole requester SHALL be granted the same cycle its req is high.
REQ-026 In RUN with a_req and b_req both high, grant SHALL go to the requester not granted most recently (round-robin); last-granted flag updates on every grant, including grants in BOOT.
REQ-027 gnt and RAM command outputs SHALL be combinational from req/state: on a grant, ram_addr/ram_din/ram_read_en/ram_write_en reflect the granted requester in that cycle; with no grant, ram_read_en=ram_write_en=0, ram_addr=0, ram_din=0.
REQ-028 Requester A grant SHALL drive ram_read_en=1, ram_write_en=0; B grant SHALL drive ram_write_en=b_we, ram_read_en=~b_we.
REQ-029 A one-cycle registered tag SHALL record the owner of each read grant; the cycle after, exactly that requester's rvalid SHALL be 1 and its rdata SHALL equal ram_dout.
REQ-030 Write grants SHALL NOT produce rvalid.
REQ-031 Back-to-back grants SHALL be supported every cycle (full throughput, read latency 1); alternating A/B reads return in grant order.
REQ-032 rdata outputs SHALL hold their last value when rvalid=0.
REQ-033 boot_done coincident with a BOOT-cycle B grant: grant completes normally; RUN arbitration starts next cycle.
REQ-034 boot_done while in RUN SHALL have no effect.

Reset
REQ-035 reset_n low SHALL immediately force: state=BOOT, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, read-tag cleared, last-granted=A (B wins first contention).
REQ-036 Reset asserted with a read outstanding SHALL discard it; no rvalid after reset_n release.
REQ-037 Grants SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-038 Reset, BOOT, b_req=1 b_we=1 addr 0..3 data 0x1884,0x1906,0x0194,0x2622 -> b_gnt each cycle, ram_write_en=1, no b_rvalid; a_req=1 throughout -> a_gnt=0.
REQ-039 boot_done pulse, a_req only, a_addr 0,1,2 consecutive -> a_gnt every cycle, a_rvalid next cycle each, a_rdata 0x1884,0x1906,0x0194.
REQ-040 RUN, a_req and b_req (read, addr 3) held high together 4 cycles, last grant A -> grants B,A,B,A; rvalids tagged correctly, b_rdata=0x2622.
REQ-041 B write addr 5 data 0xBEEF then A read addr 5 next cycle -> a_rdata=0xBEEF.
REQ-042 reset_n asserted the cycle after an A read grant -> a_rvalid stays 0, state BOOT, a_req blocked until boot_done.
REQ-043 boot_done while in RUN, both requesting -> round-robin sequence unchanged.
